pipe_sched: RTL and testbench
=============================

Name: pipe_sched

Overview:
- Pipeline hold/flush scheduler for the 5-stage core.
- Arbitrates the ex-stage requesters (branch/jump redirect, multi-cycle divide, load/store bus wait) against the external interrupt request.
- Drives a single redirect to pc_reg, plus hold and flush controls to if_id/id_ex.
- Replaces the purely combinational hold generation with a sequenced FSM that covers multi-cycle stalls, post-jump flush windows and interrupt entry.

Parameters:
FLUSH_CYCLES, 1, extra cycles flush_o stays high after the redirect cycle (0..7).
DIV_TIMEOUT, 40, maximum S_DIV cycles before a forced release with err_o.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
jump_en_i  input  1  ex requests redirect
jump_addr_i  input  32  ex redirect target
div_start_i  input  1  ex issues a divide/remainder op
div_ready_i  input  1  divider result valid (1-cycle pulse)
mem_req_i  input  1  ex issues a load/store
mem_ack_i  input  1  bus completes the access
irq_i  input  1  external interrupt, level
irq_vec_i  input  32  handler address
ex_pc_i  input  32  PC of the instruction in ex
jump_en_o  output  1  redirect pc_reg this cycle
jump_addr_o  output  32  redirect target
hold_flag_o  output  1  stall pc_reg, if_id, id_ex
flush_o  output  1  clear if_id and id_ex to NOP
irq_ack_o  output  1  interrupt accepted (1-cycle pulse)
epc_o  output  32  registered PC of the interrupted instruction
err_o  output  1  divide timeout (1-cycle pulse)

Behaviour:
- FSM states: S_RUN, S_FLUSH, S_DIV, S_MEM.
- Counters:
  - fcnt: 3 bits.
  - dcnt: $clog2(DIV_TIMEOUT)+1 bits.
- Reset (rst high at posedge): next state S_RUN, fcnt=0, dcnt=0, epc_o=0.
- While rst is high, all combinational outputs are forced to 0; jump_addr_o=0.
- Reset mid-stall or mid-flush discards the operation with no err_o.
- Outputs are combinational from state and inputs (0-cycle latency), except epc_o, which is registered.
- S_RUN, evaluated in this priority order:
  1. jump_en_i:
     - jump_en_o=1, jump_addr_o=jump_addr_i, flush_o=1, hold_flag_o=1.
     - Next state S_FLUSH with fcnt=FLUSH_CYCLES, or stay in S_RUN if FLUSH_CYCLES=0.
     - div_start_i, mem_req_i and irq_i are ignored this cycle.
  2. div_start_i:
     - hold_flag_o=1, dcnt=0, next S_DIV.
     - If div_ready_i is already high in the same cycle, there is no hold and the FSM stays in S_RUN.
  3. mem_req_i && !mem_ack_i: hold_flag_o=1, next S_MEM. mem_req_i && mem_ack_i gives no hold.
  4. irq_i:
     - jump_en_o=1, jump_addr_o=irq_vec_i, flush_o=1, hold_flag_o=1, irq_ack_o=1.
     - epc_o<=ex_pc_i.
     - Next S_FLUSH as in rule 1.
  5. Otherwise all outputs are 0.
- S_FLUSH:
  - flush_o=1, hold_flag_o=0.
  - fcnt decrements each cycle; when fcnt==1, next S_RUN.
  - jump_en_i and irq_i are ignored; irq is deferred until S_RUN.
- S_DIV:
  - hold_flag_o=1 and dcnt increments.
  - div_ready_i gives hold_flag_o=0 that same cycle, next S_RUN.
  - dcnt==DIV_TIMEOUT-1 without ready gives hold_flag_o=0 and err_o=1, next S_RUN.
  - If ready and timeout coincide, ready wins and err_o=0.
  - jump_en_i, mem_req_i and irq_i are ignored.
- S_MEM:
  - hold_flag_o=1 until mem_ack_i; the ack cycle gives hold_flag_o=0, next S_RUN.
  - The wait has no timeout. Other inputs are ignored.
- irq_i is level-sensitive and never latched. If it drops before S_RUN becomes eligible, no interrupt is taken.
- irq_ack_o is asserted at most once per accepted entry.
- jump_addr_o is 0 whenever jump_en_o=0.

Test Plan:
- Reset then idle: rst high for 2 cycles, then all inputs 0 → every output 0, epc_o=0, state S_RUN.
- Jump: jump_en_i=1, jump_addr_i=0x0000_0100 for 1 cycle (FLUSH_CYCLES=1) → that cycle jump_en_o=1, jump_addr_o=0x100, flush_o=1, hold_flag_o=1; next cycle flush_o=1 only; third cycle all 0.
- Divide:
  - div_start_i pulse, then div_ready_i 5 cycles later → hold_flag_o high for exactly 5 cycles, low in the ready cycle.
  - Same with ready never asserted → hold_flag_o high 40 cycles, err_o pulse in cycle 40, then S_RUN.
- Memory:
  - mem_req_i=1 with mem_ack_i after 3 cycles → hold_flag_o high 3 cycles.
  - mem_req_i and mem_ack_i high in the same cycle → hold_flag_o stays 0.
- Interrupt:
  - irq_i=1, irq_vec_i=0x0000_0080, ex_pc_i=0x0000_0024 in S_RUN → jump_en_o=1, jump_addr_o=0x80, irq_ack_o=1 for 1 cycle; epc_o=0x24 the next cycle.
  - Same cycle as jump_en_i=1 → jump wins, irq_ack_o=0.
  - irq_i raised during S_DIV → accepted in the first S_RUN cycle after release.
- Reset mid-S_DIV: rst asserted in cycle 3 of a divide stall → hold_flag_o=0 while rst is high, S_RUN after release, no err_o.

Source files
------------

// File: rtl/pipe_sched.sv
// pipe_sched -- pipeline hold/flush scheduler for the 5-stage core.
//
// Arbitrates the ex-stage requesters (jump redirect, multi-cycle divide,
// load/store bus wait) against the external interrupt. It produces one
// redirect for pc_reg and hold/flush controls for if_id/id_ex.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   jump_en_i/addr  ex requests a redirect to jump_addr_i
//   div_start_i     ex issues a divide; div_ready_i pulses with the result
//   mem_req_i       ex issues a load/store; mem_ack_i completes it
//   irq_i/irq_vec_i level interrupt request and handler address
//   ex_pc_i         PC of the instruction in ex (saved on interrupt entry)
//   jump_en_o/addr  redirect pc_reg this cycle (addr is 0 when not redirecting)
//   hold_flag_o     stall pc_reg, if_id, id_ex
//   flush_o         clear if_id and id_ex to NOP
//   irq_ack_o       interrupt accepted (1-cycle pulse)
//   epc_o           registered PC of the interrupted instruction
//   err_o           divide timeout (1-cycle pulse)
//
// Every output except epc_o is combinational from state and inputs.
module pipe_sched #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DIV_TIMEOUT  = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_start_i,
  input  logic        div_ready_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        irq_i,
  input  logic [31:0] irq_vec_i,
  input  logic [31:0] ex_pc_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_flag_o,
  output logic        flush_o,
  output logic        irq_ack_o,
  output logic [31:0] epc_o,
  output logic        err_o
);

  localparam int DW = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [2:0]    FC    = 3'(FLUSH_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DIV, S_MEM} state_t;

  state_t        state;
  logic [2:0]    fcnt;
  logic [DW-1:0] dcnt;

  // Output decode. rst masks everything so a reset in the middle of a
  // stall or flush releases the pipeline immediately.
  always_comb begin
    jump_en_o   = 1'b0;
    jump_addr_o = 32'd0;
    hold_flag_o = 1'b0;
    flush_o     = 1'b0;
    irq_ack_o   = 1'b0;
    err_o       = 1'b0;
    if (!rst) begin
      case (state)
        S_RUN: begin
          if (jump_en_i) begin
            jump_en_o   = 1'b1;
            jump_addr_o = jump_addr_i;
            flush_o     = 1'b1;
            hold_flag_o = 1'b1;
          end else if (div_start_i) begin
            // a divider that answers in the issue cycle needs no stall
            hold_flag_o = !div_ready_i;
          end else if (mem_req_i && !mem_ack_i) begin
            hold_flag_o = 1'b1;
          end else if (irq_i) begin
            jump_en_o   = 1'b1;
            jump_addr_o = irq_vec_i;
            flush_o     = 1'b1;
            hold_flag_o = 1'b1;
            irq_ack_o   = 1'b1;
          end
        end
        S_FLUSH: flush_o = 1'b1;
        S_DIV: begin
          // ready beats the timeout when both land in the same cycle
          if (div_ready_i)         hold_flag_o = 1'b0;
          else if (dcnt == DLAST)  err_o       = 1'b1;
          else                     hold_flag_o = 1'b1;
        end
        S_MEM:   hold_flag_o = !mem_ack_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      fcnt  <= 3'd0;
      dcnt  <= '0;
      epc_o <= 32'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (jump_en_i) begin
            if (FLUSH_CYCLES != 0) begin
              state <= S_FLUSH;
              fcnt  <= FC;
            end
          end else if (div_start_i) begin
            dcnt <= '0;
            if (!div_ready_i) state <= S_DIV;
          end else if (mem_req_i && !mem_ack_i) begin
            state <= S_MEM;
          end else if (irq_i) begin
            epc_o <= ex_pc_i;
            if (FLUSH_CYCLES != 0) begin
              state <= S_FLUSH;
              fcnt  <= FC;
            end
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt - 3'd1;
          // fcnt==0 cannot normally occur here; treat it as the last cycle
          if (fcnt <= 3'd1) state <= S_RUN;
        end
        S_DIV: begin
          dcnt <= dcnt + DW'(1);
          if (div_ready_i || dcnt == DLAST) state <= S_RUN;
        end
        S_MEM: begin
          if (mem_ack_i) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
module tb_pipe_sched;
  localparam int FLUSH = 1;
  localparam int DTO   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i, div_start_i, div_ready_i, mem_req_i, mem_ack_i, irq_i;
  logic [31:0] jump_addr_i, irq_vec_i, ex_pc_i;
  logic        jump_en_o, hold_flag_o, flush_o, irq_ack_o, err_o;
  logic [31:0] jump_addr_o, epc_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_sched #(.FLUSH_CYCLES(FLUSH), .DIV_TIMEOUT(DTO)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .div_start_i(div_start_i), .div_ready_i(div_ready_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .irq_i(irq_i), .irq_vec_i(irq_vec_i), .ex_pc_i(ex_pc_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .hold_flag_o(hold_flag_o), .flush_o(flush_o), .irq_ack_o(irq_ack_o),
    .epc_o(epc_o), .err_o(err_o)
  );

  // Behavioural model: tracks what the pipeline is waiting on as plain
  // counts (flush cycles left, cycles spent dividing, pending bus access).
  int          flush_left = 0;
  int          div_age    = -1;
  bit          mem_wait   = 1'b0;
  logic [31:0] m_epc      = 32'd0;

  initial begin
    int          nf, nd;
    bit          nm;
    logic [31:0] ne;
    logic        e_je, e_hold, e_fl, e_ack, e_err;
    logic [31:0] e_addr;
    forever begin
      @(negedge clk);
      e_je = 0; e_addr = 0; e_hold = 0; e_fl = 0; e_ack = 0; e_err = 0;
      nf = flush_left; nd = div_age; nm = mem_wait; ne = m_epc;
      if (rst) begin
        nf = 0; nd = -1; nm = 0; ne = 0;
      end else if (flush_left > 0) begin
        e_fl = 1; nf = flush_left - 1;
      end else if (div_age >= 0) begin
        if (div_ready_i) nd = -1;
        else if (div_age == DTO - 1) begin e_err = 1; nd = -1; end
        else begin e_hold = 1; nd = div_age + 1; end
      end else if (mem_wait) begin
        if (mem_ack_i) nm = 0; else e_hold = 1;
      end else if (jump_en_i) begin
        e_je = 1; e_addr = jump_addr_i; e_fl = 1; e_hold = 1; nf = FLUSH;
      end else if (div_start_i) begin
        if (!div_ready_i) begin e_hold = 1; nd = 0; end
      end else if (mem_req_i && !mem_ack_i) begin
        e_hold = 1; nm = 1;
      end else if (irq_i) begin
        e_je = 1; e_addr = irq_vec_i; e_fl = 1; e_hold = 1; e_ack = 1;
        ne = ex_pc_i; nf = FLUSH;
      end
      if (chk_en) begin
        vectors++;
        if ({jump_en_o, jump_addr_o, hold_flag_o, flush_o, irq_ack_o, epc_o, err_o} !==
            {e_je, e_addr, e_hold, e_fl, e_ack, m_epc, e_err}) begin
          miscompares++;
          $display("FAIL model t=%0t got je=%b addr=%h hold=%b fl=%b ack=%b epc=%h err=%b exp je=%b addr=%h hold=%b fl=%b ack=%b epc=%h err=%b",
                   $time, jump_en_o, jump_addr_o, hold_flag_o, flush_o, irq_ack_o, epc_o, err_o,
                   e_je, e_addr, e_hold, e_fl, e_ack, m_epc, e_err);
        end
      end
      @(posedge clk);
      flush_left = nf; div_age = nd; mem_wait = nm; m_epc = ne;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    jump_en_i = 0; jump_addr_i = 0; div_start_i = 0; div_ready_i = 0;
    mem_req_i = 0; mem_ack_i = 0; irq_i = 0; irq_vec_i = 0; ex_pc_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hcnt, err_at;
    idle();
    rst = 1;
    step(); chk_en = 1;
    @(negedge clk);
    lit("rst_hold", {31'd0, hold_flag_o}, 0);
    step(); rst = 0;
    @(negedge clk);
    lit("idle_outs", {26'd0, jump_en_o, hold_flag_o, flush_o, irq_ack_o, err_o, 1'b0}, 0);
    lit("idle_epc", epc_o, 0);

    // jump with one flush cycle
    step(); jump_en_i = 1; jump_addr_i = 32'h100;
    @(negedge clk);
    lit("jmp_addr", jump_addr_o, 32'h100);
    lit("jmp_ctl", {28'd0, jump_en_o, flush_o, hold_flag_o, irq_ack_o}, 32'he);
    step(); idle();
    @(negedge clk);
    lit("jmp_flush1", {29'd0, jump_en_o, flush_o, hold_flag_o}, 32'h2);
    step();
    @(negedge clk);
    lit("jmp_done", {30'd0, flush_o, hold_flag_o}, 0);

    // divide, ready 5 cycles after start
    step(); div_start_i = 1; hcnt = 0;
    @(negedge clk); if (hold_flag_o) hcnt++;
    for (int k = 1; k <= 5; k++) begin
      step(); div_start_i = 0; div_ready_i = (k == 5);
      @(negedge clk); if (hold_flag_o) hcnt++;
    end
    lit("div_ready_hold", hcnt, 5);
    lit("div_ready_cyc", {31'd0, hold_flag_o}, 0);
    step(); idle();

    // divide timeout
    step(); div_start_i = 1; hcnt = 0; err_at = -1;
    @(negedge clk); if (hold_flag_o) hcnt++;
    for (int k = 1; k <= 45; k++) begin
      step(); div_start_i = 0;
      @(negedge clk);
      if (hold_flag_o) hcnt++;
      if (err_o && err_at < 0) err_at = k;
    end
    lit("div_to_hold", hcnt, 40);
    lit("div_to_err", err_at, 40);

    // memory wait of 3 cycles
    step(); mem_req_i = 1; hcnt = 0;
    @(negedge clk); if (hold_flag_o) hcnt++;
    for (int k = 1; k <= 3; k++) begin
      step(); mem_req_i = 0; mem_ack_i = (k == 3);
      @(negedge clk); if (hold_flag_o) hcnt++;
    end
    lit("mem_hold", hcnt, 3);
    step(); idle(); mem_req_i = 1; mem_ack_i = 1;
    @(negedge clk);
    lit("mem_same_cyc", {31'd0, hold_flag_o}, 0);

    // interrupt entry
    step(); idle(); irq_i = 1; irq_vec_i = 32'h80; ex_pc_i = 32'h24;
    @(negedge clk);
    lit("irq_addr", jump_addr_o, 32'h80);
    lit("irq_ctl", {30'd0, jump_en_o, irq_ack_o}, 32'h3);
    step(); idle();
    @(negedge clk);
    lit("irq_epc", epc_o, 32'h24);
    lit("irq_ack_once", {31'd0, irq_ack_o}, 0);

    // jump beats interrupt
    step(); jump_en_i = 1; jump_addr_i = 32'h300; irq_i = 1; irq_vec_i = 32'h80;
    @(negedge clk);
    lit("jmp_vs_irq_addr", jump_addr_o, 32'h300);
    lit("jmp_vs_irq_ack", {31'd0, irq_ack_o}, 0);
    step(); idle();
    step();

    // interrupt raised while dividing is taken right after release
    step(); div_start_i = 1;
    for (int k = 1; k <= 4; k++) begin
      step(); div_start_i = 0;
      if (k == 2) begin irq_i = 1; irq_vec_i = 32'h200; ex_pc_i = 32'h40; end
      div_ready_i = (k == 4);
      @(negedge clk);
      if (k < 4) lit("irq_in_div_ack", {31'd0, irq_ack_o}, 0);
    end
    step(); div_ready_i = 0;
    @(negedge clk);
    lit("irq_after_div", {30'd0, jump_en_o, irq_ack_o}, 32'h3);
    lit("irq_after_div_addr", jump_addr_o, 32'h200);
    step(); idle();
    @(negedge clk);
    lit("irq_after_div_epc", epc_o, 32'h40);
    step();

    // reset in cycle 3 of a divide stall
    step(); div_start_i = 1;
    for (int k = 1; k <= 2; k++) begin step(); div_start_i = 0; end
    step(); rst = 1;
    @(negedge clk);
    lit("rst_div_hold", {31'd0, hold_flag_o}, 0);
    step();
    step(); rst = 0; err_at = -1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if ((hold_flag_o || err_o) && err_at < 0) err_at = k;
      step();
    end
    lit("rst_div_quiet", err_at, -1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
